// File: rtl/line_clear_ctl.sv
// Line-clear controller: scans the board bottom-up, compacts non-full rows downward and zero-fills the top.
// Optional scoring is compiled in with `define LINE_CLEAR_SCORE_EN.
module line_clear_ctl #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            lock_en,
    input  logic [3:0]      level,
    input  logic [COLS-1:0] ram_rdata,
    output logic [4:0]      ram_addr,
    output logic            ram_we,
    output logic [COLS-1:0] ram_wdata,
    output logic            busy,
    output logic            done,
    output logic [4:0]      lines_cleared,
    output logic [14:0]     score_add,
    output logic [15:0]     total_lines
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, READ, EVAL, ZERO, DONE} state_t;

    state_t      state;
    logic [4:0]  rd_row;
    logic [4:0]  wr_row;
    logic [5:0]  cnt;
    logic        row_full;
    logic [5:0]  fin_cnt;
    logic        go_done;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [5:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

`ifdef LINE_CLEAR_SCORE_EN
    function automatic logic [14:0] score_of(input logic [5:0] n, input logic [3:0] lvl);
        logic [14:0] base;
        logic [14:0] mult;
        case (n)
            6'd0:    base = 15'd0;
            6'd1:    base = 15'd40;
            6'd2:    base = 15'd100;
            6'd3:    base = 15'd300;
            default: base = 15'd1200;
        endcase
        mult = 15'(lvl) + 15'd1;
        return base * mult;
    endfunction
`else
    logic unused_level;
    assign unused_level = ^level;
`endif

    assign row_full = &ram_rdata;

    // Count including the row being evaluated this cycle, so the exit decision sees it.
    always_comb begin
        fin_cnt = cnt;
        if (state == EVAL && row_full)
            fin_cnt = cnt + 6'd1;
        go_done = (state == EVAL && rd_row == 5'd0 && fin_cnt == 6'd0) ||
                  (state == ZERO && wr_row == 5'd0);
    end

    // Read data only arrives in EVAL, so the copy-down write is steered combinationally.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state)
            READ: ram_addr = rd_row;
            EVAL: begin
                if (!row_full && wr_row != rd_row) begin
                    ram_addr  = wr_row;
                    ram_we    = 1'b1;
                    ram_wdata = ram_rdata;
                end
            end
            ZERO: begin
                ram_addr = wr_row;
                ram_we   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rd_row        <= '0;
            wr_row        <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            score_add     <= '0;
            total_lines   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (lock_en) begin
                        rd_row <= LAST_ROW;
                        wr_row <= LAST_ROW;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: state <= EVAL;
                EVAL: begin
                    cnt <= fin_cnt;
                    if (!row_full)
                        wr_row <= wr_row - 5'd1;
                    if (rd_row != 5'd0) begin
                        rd_row <= rd_row - 5'd1;
                        state  <= READ;
                    end else if (fin_cnt != 6'd0) begin
                        state <= ZERO;
                    end else begin
                        state <= DONE;
                    end
                end
                ZERO: begin
                    wr_row <= wr_row - 5'd1;
                    if (wr_row == 5'd0)
                        state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (go_done) begin
                done          <= 1'b1;
                lines_cleared <= (fin_cnt > 6'd31) ? 5'd31 : fin_cnt[4:0];
                total_lines   <= sat_add(total_lines, fin_cnt);
`ifdef LINE_CLEAR_SCORE_EN
                score_add     <= score_of(fin_cnt, level);
`else
                score_add     <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/line_clear_ctl.md
LINE_CLEAR_CTL -- requirements
Module: line_clear_ctl

Interface
REQ-001 Parameter ROWS, default 20: playfield row count, 2..32; row 0 is the top row, row ROWS-1 is the bottom row.
REQ-002 Parameter COLS, default 10: playfield column count, i.e. bits per row word.
REQ-003 pclk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 lock_en  in  1  piece-locked strobe; starts one clear pass.
REQ-006 level  in  4  current game level, used for score scaling.
REQ-007 ram_rdata  in  COLS  row word, valid the cycle after its address is presented with ram_we=0.
REQ-008 ram_addr  out  5  row address to the single-port board RAM.
REQ-009 ram_we  out  1  row write enable.
REQ-010 ram_wdata  out  COLS  row word to write.
REQ-011 busy  out  1  high from the cycle after start through the DONE cycle.
REQ-012 done  out  1  one-cycle pulse when a pass completes.
REQ-013 lines_cleared  out  5  full rows removed in the last pass; held until the next DONE.
REQ-014 score_add  out  15  score increment for the last pass; held until the next DONE.
REQ-015 total_lines  out  16  running count of cleared lines, saturating at 65535.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, EVAL, ZERO and DONE; it SHALL leave IDLE only when lock_en=1 is sampled in IDLE.
REQ-017 On start, the FSM SHALL set rd_row=wr_row=ROWS-1 and cnt=0, and SHALL enter READ.
REQ-018 In READ: ram_addr=rd_row, ram_we=0; the next state SHALL be EVAL.
REQ-019 In EVAL, a row is full when ram_rdata is all ones; on a full row: cnt+1, no write.
REQ-020 In EVAL, on a non-full row with wr_row!=rd_row: ram_addr=wr_row, ram_we=1, ram_wdata=ram_rdata, then wr_row-1.
REQ-021 In EVAL, on a non-full row with wr_row==rd_row: no write, then wr_row-1.
REQ-022 EVAL SHALL go to READ with rd_row-1 if rd_row>0; otherwise it SHALL go to ZERO if cnt>0, else to DONE.
REQ-023 In ZERO, rows wr_row down to 0 SHALL be written with all zeros, one row per cycle, for exactly cnt cycles; then the FSM SHALL go to DONE.
REQ-024 In DONE: done=1; lines_cleared=cnt; score_add and total_lines updated; next state IDLE.
REQ-025 Latency: done SHALL assert exactly 2*ROWS+cnt+1 cycles after the start sample.
REQ-026 ram_we SHALL be 0 in IDLE, READ and DONE.
REQ-027 lock_en asserted while busy=1 SHALL be ignored and not queued.
REQ-028 lock_en sampled in the DONE cycle SHALL be ignored; a start is accepted only from IDLE.
REQ-029 total_lines SHALL add cnt, saturating at 65535 and never wrapping.

Reset
REQ-030 rst=1 SHALL force IDLE immediately, without waiting for a clock edge, including mid-pass.
REQ-031 Reset values: ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, lines_cleared=0, score_add=0, total_lines=0, cnt=0.
REQ-032 After reset deasserts, the controller SHALL take no RAM action until a new lock_en is sampled.

Configuration
REQ-033 Macro LINE_CLEAR_SCORE_EN defined: at DONE, score_add = base*(level+1), with base 0/40/100/300/1200 for cnt 0/1/2/3/>=4.
REQ-034 Macro LINE_CLEAR_SCORE_EN undefined: score_add is constant 0 and the scoring logic is absent; all other behaviour is unchanged.

Verification
REQ-035 Empty board, lock_en pulse -> no ram_we ever asserted; done at start+41; lines_cleared=0; score_add=0.
REQ-036 Row 19 full, row 18=0x001, others 0, level=0 -> row19<=0x001, row0<=0; done at start+42; lines_cleared=1; score_add=40 (macro on).
REQ-037 Rows 16-19 full, level=2 -> rows 0-3 zeroed, rows 16-19 end holding the old rows 12-15; lines_cleared=4; score_add=3600 (macro on), 0 (macro off).
REQ-038 lock_en held high for the whole pass -> exactly one pass; after DONE, one more pass from IDLE because lock_en is still high.
REQ-039 rst asserted in the 10th cycle of a pass -> ram_we=0 and busy=0 immediately, no done pulse, total_lines unchanged.
REQ-040 total_lines preset near saturation by repeated 4-line passes -> it reaches 65535 and stays there.
